// File: rtl/hub_fp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hub_fp_pkg
// Description : Shared types and constant helpers for the HUB floating-point
//               adder front end (operand layout, special-case codes).
// Revision    : 1.0 - initial release
// ============================================================================
package hub_fp_pkg;

    localparam int c_hub_m     = 23;
    localparam int c_hub_e     = 8;
    localparam int c_hub_extra = 7;

    // HUB operand layout, MSB to LSB: sign, biased exponent, fraction.
    typedef struct packed {
        logic                 sign;
        logic [c_hub_e-1:0]   exp;
        logic [c_hub_m-1:0]   frac;
    } hub_operand_t;

    typedef enum logic [1:0] {
        SPECIAL_NORMAL  = 2'b00,
        SPECIAL_ZERO    = 2'b01,
        SPECIAL_INF     = 2'b10,
        SPECIAL_INF_SUB = 2'b11
    } special_e;

    // Width of the extended intermediate mantissa.
    function automatic int ext_mant_width(input int m, input int extra);
        return m + extra;
    endfunction

    // Exponent code used by infinities and NaNs.
    function automatic int exp_all_ones(input int e);
        return (1 << e) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hub_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : hub_pipe_reg
// Description : One-entry valid/ready pipeline register. Accepts new data when
//               empty or when the held entry is leaving in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module hub_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    assign in_ready  = !r_valid || out_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;

    // Hold the entry until it is consumed; load new data only on a transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (in_ready) begin
                r_valid <= in_valid;
            end
            if (in_valid && in_ready) begin
                r_data <= in_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hub_align_stage.sv
`default_nettype none
// ============================================================================
// Module      : hub_align_stage
// Description : Two-stage operand-alignment front end of the HUB FP adder.
//               Stage 1 captures operands, exponent difference and magnitude
//               order; stage 2 swaps, builds extended mantissas, clamps the
//               shift and classifies special operands.
//               The operand struct follows the package widths, so M and E
//               must keep their package defaults.
// Revision    : 1.0 - initial release
// ============================================================================
module hub_align_stage
    import hub_fp_pkg::*;
#(
    parameter int M                   = c_hub_m,
    parameter int E                   = c_hub_e,
    parameter int EXTRA_BITS_MANTISSA = c_hub_extra
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [E+M:0]                     x,
    input  logic [E+M:0]                     y,
    input  logic                             sub,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [M+EXTRA_BITS_MANTISSA-1:0] big_mant,
    output logic [M+EXTRA_BITS_MANTISSA-1:0] small_mant,
    output logic [E-1:0]                     big_exp,
    output logic                             big_sign,
    output logic                             eff_sub,
    output logic [E:0]                       shift_amount,
    output logic                             right_shift,
    output logic                             arithmetic_shift,
    output logic [1:0]                       special
);

    localparam int             c_mw        = ext_mant_width(M, EXTRA_BITS_MANTISSA);
    localparam int             c_shift_w   = E + 1;
    localparam logic [E-1:0]   c_exp_ones  = E'(exp_all_ones(E));
    localparam logic [E:0]     c_shift_max = c_shift_w'(c_mw);
    localparam logic [E:0]     c_zero_diff = '0;

    typedef struct packed {
        hub_operand_t op_x;
        hub_operand_t op_y;
        logic [E:0]   diff;
        logic         x_ge_y;
    } s1_t;

    typedef struct packed {
        logic [c_mw-1:0] big_mant;
        logic [c_mw-1:0] small_mant;
        logic [E-1:0]    big_exp;
        logic            big_sign;
        logic            eff_sub;
        logic [E:0]      shift_amount;
        logic [1:0]      special;
    } s2_t;

    // Hidden 1, fraction and ILSB placed below a guard 0; zero operands vanish.
    function automatic logic [c_mw-1:0] ext_mant(input hub_operand_t op);
        logic [c_mw-1:0] v;
        v = c_mw'({2'b01, op.frac, 1'b1}) << (EXTRA_BITS_MANTISSA - 3);
        if (op.exp == '0) begin
            v = '0;
        end
        return v;
    endfunction

    logic [1:0]   r_rst_sync;
    logic         w_rst_n_int;
    hub_operand_t w_x;
    hub_operand_t w_y;
    s1_t          w_s1_in;
    s1_t          w_s1;
    logic         w_s1_in_ready;
    logic         w_s1_valid;
    logic         w_s2_in_ready;
    logic [E:0]   w_abs_diff;
    special_e     w_special;
    s2_t          w_s2_in;
    s2_t          w_s2;

    // Assert internal reset immediately, release it two clocks after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n_int = r_rst_sync[1];

    // ---------------- stage 1: capture, exponent difference, order ----------
    assign w_x = hub_operand_t'(x);
    assign w_y = hub_operand_t'({y[E+M] ^ sub, y[E+M-1:0]});

    assign w_s1_in.op_x   = w_x;
    assign w_s1_in.op_y   = w_y;
    assign w_s1_in.diff   = {1'b0, w_x.exp} - {1'b0, w_y.exp};
    assign w_s1_in.x_ge_y = (w_x.exp > w_y.exp) ||
                            ((w_x.exp == w_y.exp) && (w_x.frac >= w_y.frac));

    // No pair is taken while the internal reset is still held.
    assign in_ready = w_s1_in_ready && w_rst_n_int;

    hub_pipe_reg #(.WIDTH($bits(s1_t))) u_stage1 (
        .clk       (clk),
        .rst_n     (w_rst_n_int),
        .in_valid  (in_valid && w_rst_n_int),
        .in_ready  (w_s1_in_ready),
        .in_data   (w_s1_in),
        .out_valid (w_s1_valid),
        .out_ready (w_s2_in_ready),
        .out_data  (w_s1)
    );

    // ---------------- stage 2: swap, extend, clamp, classify ----------------
    assign w_abs_diff = w_s1.x_ge_y ? w_s1.diff : (c_zero_diff - w_s1.diff);

    assign w_s2_in.big_mant     = ext_mant(w_s1.x_ge_y ? w_s1.op_x : w_s1.op_y);
    assign w_s2_in.small_mant   = ext_mant(w_s1.x_ge_y ? w_s1.op_y : w_s1.op_x);
    assign w_s2_in.big_exp      = w_s1.x_ge_y ? w_s1.op_x.exp  : w_s1.op_y.exp;
    assign w_s2_in.big_sign     = w_s1.x_ge_y ? w_s1.op_x.sign : w_s1.op_y.sign;
    assign w_s2_in.eff_sub      = w_s1.op_x.sign ^ w_s1.op_y.sign;
    assign w_s2_in.shift_amount = (w_abs_diff > c_shift_max) ? c_shift_max : w_abs_diff;
    assign w_s2_in.special      = w_special;

    // Infinity/NaN takes priority over a zero operand; inf-inf under subtraction is flagged.
    always_comb begin
        w_special = SPECIAL_NORMAL;
        if ((w_s1.op_x.exp == c_exp_ones) && (w_s1.op_y.exp == c_exp_ones) &&
            (w_s1.op_x.sign ^ w_s1.op_y.sign)) begin
            w_special = SPECIAL_INF_SUB;
        end else if ((w_s1.op_x.exp == c_exp_ones) || (w_s1.op_y.exp == c_exp_ones)) begin
            w_special = SPECIAL_INF;
        end else if ((w_s1.op_x.exp == '0) || (w_s1.op_y.exp == '0)) begin
            w_special = SPECIAL_ZERO;
        end
    end

    hub_pipe_reg #(.WIDTH($bits(s2_t))) u_stage2 (
        .clk       (clk),
        .rst_n     (w_rst_n_int),
        .in_valid  (w_s1_valid),
        .in_ready  (w_s2_in_ready),
        .in_data   (w_s2_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_s2)
    );

    assign big_mant         = w_s2.big_mant;
    assign small_mant       = w_s2.small_mant;
    assign big_exp          = w_s2.big_exp;
    assign big_sign         = w_s2.big_sign;
    assign eff_sub          = w_s2.eff_sub;
    assign shift_amount     = w_s2.shift_amount;
    assign special          = w_s2.special;
    assign right_shift      = out_valid;
    assign arithmetic_shift = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_hub_align_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_hub_align_stage
// Description : Self-checking bench for hub_align_stage: directed cases,
//               back-pressure, async reset and a randomized stream checked
//               against an arithmetic reference model and an in-flight queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hub_align_stage;

    localparam int c_m  = 23;
    localparam int c_e  = 8;
    localparam int c_x  = 7;
    localparam int c_mw = c_m + c_x;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       x;
    logic [31:0]       y;
    logic              sub;
    logic              out_valid;
    logic              out_ready;
    logic [c_mw-1:0]   big_mant;
    logic [c_mw-1:0]   small_mant;
    logic [c_e-1:0]    big_exp;
    logic              big_sign;
    logic              eff_sub;
    logic [c_e:0]      shift_amount;
    logic              right_shift;
    logic              arithmetic_shift;
    logic [1:0]        special;

    typedef struct {
        logic [c_mw-1:0] bm;
        logic [c_mw-1:0] sm;
        logic [7:0]      be;
        logic            bs;
        logic            es;
        logic [8:0]      sh;
        logic [1:0]      sp;
        int              cyc;
    } exp_t;

    exp_t  q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    bit    rst_done = 0;
    bit    last_acc;
    bit    last_in_ready;
    bit    stall_prev = 0;
    logic [95:0] stall_snap;

    hub_align_stage u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .x                (x),
        .y                (y),
        .sub              (sub),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .big_mant         (big_mant),
        .small_mant       (small_mant),
        .big_exp          (big_exp),
        .big_sign         (big_sign),
        .eff_sub          (eff_sub),
        .shift_amount     (shift_amount),
        .right_shift      (right_shift),
        .arithmetic_shift (arithmetic_shift),
        .special          (special)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Extended mantissa from its definition: (1.f with ILSB) scaled up by the extra zeros.
    function automatic longint ext_ref(input int e, input longint f);
        if (e == 0) return 0;
        return (((longint'(1) << c_m) + f) * 2 + 1) * (longint'(1) << (c_x - 3));
    endfunction

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t   r;
        int     ea, eb, d;
        longint fa, fb;
        bit     sa, sb, xbig, ia, ib;
        ea = int'(a[30:23]);  eb = int'(b[30:23]);
        fa = longint'(a[22:0]); fb = longint'(b[22:0]);
        sa = a[31]; sb = b[31] ^ s;
        xbig = (longint'(ea) * (longint'(1) << c_m) + fa) >= (longint'(eb) * (longint'(1) << c_m) + fb);
        d = ea - eb;
        if (d < 0) d = -d;
        if (d > c_mw) d = c_mw;
        r.bm = c_mw'(xbig ? ext_ref(ea, fa) : ext_ref(eb, fb));
        r.sm = c_mw'(xbig ? ext_ref(eb, fb) : ext_ref(ea, fa));
        r.be = 8'(xbig ? ea : eb);
        r.bs = xbig ? sa : sb;
        r.es = sa ^ sb;
        r.sh = 9'(d);
        ia = (ea == 255); ib = (eb == 255);
        if (ia && ib && (sa != sb))      r.sp = 2'b11;
        else if (ia || ib)               r.sp = 2'b10;
        else if (ea == 0 || eb == 0)     r.sp = 2'b01;
        else                             r.sp = 2'b00;
        r.cyc = 0;
        return r;
    endfunction

    // One clock: check observable behaviour against the in-flight queue, then advance.
    task automatic step();
        exp_t e;
        logic [95:0] snap;
        @(negedge clk);
        snap = {big_mant, small_mant, big_exp, big_sign, eff_sub, shift_amount, special, 25'd0};
        last_in_ready = in_ready;
        last_acc = in_valid && in_ready;
        if (rst_done) begin
            chk("in_ready", in_ready, !(q.size() == 2 && !out_ready));
            chk("out_valid", out_valid, (q.size() > 0) && (cyc - q[0].cyc >= 2));
        end
        if (stall_prev && out_valid) chk("stall_hold", snap, stall_snap);
        if (out_valid) begin
            chk("right_shift", right_shift, 1'b1);
            chk("arith_shift", arithmetic_shift, 1'b0);
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_out", 1'b1, 1'b0);
            end else begin
                e = q.pop_front();
                chk("big_mant", big_mant, e.bm);
                chk("small_mant", small_mant, e.sm);
                chk("big_exp", big_exp, e.be);
                chk("big_sign", big_sign, e.bs);
                chk("eff_sub", eff_sub, e.es);
                chk("shift_amount", shift_amount, e.sh);
                chk("special", special, e.sp);
            end
        end
        if (last_acc) begin
            e = model(x, y, sub);
            e.cyc = cyc;
            q.push_back(e);
        end
        stall_prev = out_valid && !out_ready;
        stall_snap = snap;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s);
        bit done;
        done = 0;
        in_valid = 1'b1; x = a; y = b; sub = s;
        for (int i = 0; i < 50 && !done; i++) begin
            step();
            done = last_acc;
        end
        if (!done) chk("send_timeout", 1'b0, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 30 && q.size() > 0; i++) step();
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic wait_ready();
        bit ok;
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
        end
        chk("ready_after_reset", ok, 1'b1);
        @(posedge clk);
        #1;
        rst_done = 1;
    endtask

    function automatic logic [31:0] rnd_op(input logic [7:0] share_exp, input bit use_share);
        logic [7:0] ex;
        int cls;
        cls = int'($urandom_range(0, 9));
        if (use_share)      ex = share_exp;
        else if (cls == 0)  ex = 8'h00;
        else if (cls == 1)  ex = 8'hFF;
        else                ex = 8'($urandom_range(0, 255));
        return {1'($urandom), ex, 23'($urandom)};
    endfunction

    logic [31:0] pairs_x [5];
    logic [31:0] pairs_y [5];

    initial begin
        int idx;
        bit pending;
        rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0; sub = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_big_mant", big_mant, '0);
        chk("rst_small_mant", small_mant, '0);
        chk("rst_shift", shift_amount, '0);
        chk("rst_right_shift", right_shift, 1'b0);
        chk("rst_arith_shift", arithmetic_shift, 1'b0);
        chk("rst_special", special, 2'b00);
        rst_n = 1'b1;
        wait_ready();

        // Directed cases
        send(32'h3F800000, 32'h3E800000, 1'b0); drain();
        send(32'h3E800000, 32'hBF800000, 1'b0); drain();
        send({1'b0, 8'hC8, 23'h123456}, {1'b0, 8'h10, 23'h000001}, 1'b0); drain();
        send(32'h3F800000, 32'h00000000, 1'b0); drain();
        send(32'h7F800000, 32'h7F800000, 1'b1); drain();
        send(32'h7F800000, 32'h7F800000, 1'b0); drain();
        send(32'h40490FDB, 32'hC0490FDB, 1'b0); drain();
        send(32'h40400000, 32'h40600000, 1'b1); drain();
        send(32'h3F800000, 32'h4F000000, 1'b0); drain();

        // Back-pressure: five pairs back to back, output stalled for cycles 3-6
        for (int i = 0; i < 5; i++) begin
            pairs_x[i] = 32'h3F800000 + 32'(i * 32'h00812345);
            pairs_y[i] = 32'h3E000000 + 32'(i * 32'h01003000);
        end
        idx = 0;
        for (int k = 0; k < 14; k++) begin
            out_ready = !(k >= 3 && k <= 6);
            in_valid  = (idx < 5);
            x = pairs_x[idx % 5]; y = pairs_y[idx % 5]; sub = 1'b0;
            step();
            if (k == 3) chk("bp_in_ready_drop", last_in_ready, 1'b0);
            if (last_acc) idx++;
        end
        in_valid = 1'b0;
        chk("bp_all_sent", 32'(idx), 32'd5);
        drain();

        // Async reset while both stages hold a pair
        out_ready = 1'b0;
        send(32'h40000000, 32'h3F000000, 1'b0);
        send(32'h41000000, 32'h3F000000, 1'b1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 1'b0);
        chk("async_rst_big_mant", big_mant, '0);
        q.delete();
        rst_done = 0;
        stall_prev = 0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        wait_ready();
        send(32'h3F800000, 32'h3E800000, 1'b0);
        drain();

        // Randomized stream with random back-pressure
        pending = 0;
        for (int i = 0; i < 400; i++) begin
            if (!pending) begin
                x = rnd_op(8'h00, 1'b0);
                y = rnd_op(x[30:23], $urandom_range(0, 3) == 0);
                sub = 1'($urandom);
            end
            in_valid  = pending || ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            step();
            pending = in_valid && !last_acc;
        end
        in_valid = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
